rtg_fetch_responder: RTL

- SDRAM-side responder for the RTG VideoStream fetch port. It services `fetch_req`/`fetch_addr`/`fetch_pri` from the display fetcher.
- Each request becomes one burst read on the SDRAM controller's video slot. The responder returns `fetch_ack` followed by `BURST_LEN` `fetch_fill`/`fetch_d` words.
- It sits between `rtg_video` and the SDRAM controller. It also owns priority escalation, so the display FIFO cannot be starved by CPU traffic.

---
 rtl/rtg_pkg.sv | 20 ++
 rtl/rtg_fetch_responder_if.sv | 29 ++
 rtl/rtg_fetch_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rtg_pkg.sv
// Shared types and constants for the RTG video fetch path.
package rtg_pkg;

    localparam int RTG_ADDR_W = 26;
    localparam int RTG_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } rtg_state_t;

    // Clears the byte-offset bits within one burst of 16-bit words.
    function automatic logic [RTG_ADDR_W-1:0] burst_align_mask(input int burst_len);
        logic [RTG_ADDR_W-1:0] span;
        span = RTG_ADDR_W'(burst_len * 2 - 1);
        return ~span;
    endfunction

endpackage

// File: rtl/rtg_fetch_responder_if.sv
// Bundle of fetcher-side and SDRAM-side signals around the fetch responder.
interface rtg_fetch_responder_if;
    import rtg_pkg::*;

    logic [RTG_ADDR_W-1:0] fetch_addr;
    logic                  fetch_req;
    logic                  fetch_pri;
    logic                  fetch_ack;
    logic                  fetch_fill;
    logic [RTG_DATA_W-1:0] fetch_d;
    logic                  sd_req;
    logic [RTG_ADDR_W-1:0] sd_addr;
    logic                  sd_pri;
    logic                  sd_grant;
    logic                  sd_rvalid;
    logic [RTG_DATA_W-1:0] sd_rdata;
    logic                  timeout_err;

    modport master (
        output fetch_addr, fetch_req, fetch_pri, sd_grant, sd_rvalid, sd_rdata,
        input  fetch_ack, fetch_fill, fetch_d, sd_req, sd_addr, sd_pri, timeout_err
    );

    modport slave (
        input  fetch_addr, fetch_req, fetch_pri, sd_grant, sd_rvalid, sd_rdata,
        output fetch_ack, fetch_fill, fetch_d, sd_req, sd_addr, sd_pri, timeout_err
    );

endinterface

// File: rtl/rtg_fetch_responder.sv
// Turns display fetch requests into SDRAM video-slot burst reads, escalating
// priority when the grant is slow and abandoning bursts whose data stalls.
module rtg_fetch_responder
    import rtg_pkg::*;
#(
    parameter int BURST_LEN    = 8,
    parameter int PRI_WAIT     = 64,
    parameter int DATA_TIMEOUT = 255
) (
    input  logic                  clk_114,
    input  logic                  reset,
    rtg_fetch_responder_if.slave  bus
);

    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int WAIT_W = $clog2(PRI_WAIT + 1);
    localparam int TMO_W  = $clog2(DATA_TIMEOUT + 1);

    localparam logic [BEAT_W-1:0]     BEATS    = BEAT_W'(BURST_LEN);
    localparam logic [WAIT_W-1:0]     WAIT_LIM = WAIT_W'(PRI_WAIT);
    localparam logic [TMO_W-1:0]      TMO_LIM  = TMO_W'(DATA_TIMEOUT);
    localparam logic [RTG_ADDR_W-1:0] ALIGN    = burst_align_mask(BURST_LEN);

    rtg_state_t            state, state_nx;
    logic [BEAT_W-1:0]     beat_ctr, beat_nx;
    logic [WAIT_W-1:0]     wait_ctr, wait_nx;
    logic [TMO_W-1:0]      tmo_ctr, tmo_nx;
    logic                  ack_q, ack_nx;
    logic                  fill_q, fill_nx;
    logic [RTG_DATA_W-1:0] d_q, d_nx;
    logic                  req_q, req_nx;
    logic [RTG_ADDR_W-1:0] addr_q, addr_nx;
    logic                  pri_q, pri_nx;
    logic                  err_q, err_nx;

    always_ff @(posedge clk_114) begin
        if (reset) begin
            state    <= IDLE;
            beat_ctr <= '0;
            wait_ctr <= '0;
            tmo_ctr  <= '0;
            ack_q    <= 1'b0;
            fill_q   <= 1'b0;
            d_q      <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            pri_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_ctr <= beat_nx;
            wait_ctr <= wait_nx;
            tmo_ctr  <= tmo_nx;
            ack_q    <= ack_nx;
            fill_q   <= fill_nx;
            d_q      <= d_nx;
            req_q    <= req_nx;
            addr_q   <= addr_nx;
            pri_q    <= pri_nx;
            err_q    <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        beat_nx  = beat_ctr;
        wait_nx  = wait_ctr;
        tmo_nx   = tmo_ctr;
        ack_nx   = 1'b0;
        fill_nx  = 1'b0;
        d_nx     = d_q;
        req_nx   = req_q;
        addr_nx  = addr_q;
        pri_nx   = pri_q;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                if (bus.fetch_req) begin
                    state_nx = REQ;
                    addr_nx  = bus.fetch_addr & ALIGN;
                    req_nx   = 1'b1;
                    pri_nx   = bus.fetch_pri;
                    wait_nx  = '0;
                end
            end
            REQ: begin
                // A grant beats a simultaneous withdrawal: the slot is already ours.
                if (bus.sd_grant) begin
                    state_nx = DATA;
                    req_nx   = 1'b0;
                    pri_nx   = 1'b0;
                    ack_nx   = 1'b1;
                    beat_nx  = '0;
                    tmo_nx   = '0;
                end else if (!bus.fetch_req) begin
                    state_nx = IDLE;
                    req_nx   = 1'b0;
                    pri_nx   = 1'b0;
                end else begin
                    if (wait_ctr != WAIT_LIM) begin
                        wait_nx = wait_ctr + 1'b1;
                    end
                    pri_nx = bus.fetch_pri || (wait_nx >= WAIT_LIM);
                end
            end
            DATA: begin
                // Completion is recognised one cycle after the last fill, so the
                // fill cycle itself is still DATA and stray beats there are dropped.
                if (beat_ctr == BEATS) begin
                    state_nx = IDLE;
                end else begin
                    tmo_nx = tmo_ctr + 1'b1;
                    if (tmo_nx == TMO_LIM) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end else if (bus.sd_rvalid) begin
                        fill_nx = 1'b1;
                        d_nx    = bus.sd_rdata;
                        beat_nx = beat_ctr + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.fetch_ack   = ack_q;
    assign bus.fetch_fill  = fill_q;
    assign bus.fetch_d     = d_q;
    assign bus.sd_req      = req_q;
    assign bus.sd_addr     = addr_q;
    assign bus.sd_pri      = pri_q;
    assign bus.timeout_err = err_q;

endmodule
